// File: rtl/prediction_table_pkg.sv
// Shared branch-predictor definitions: default geometry, index-width helper
// and the default-geometry BTB entry layout.
package bp_pkg;

  localparam int AW_DEF       = 32;
  localparam int NENTRIES_DEF = 16;

  function automatic int iw_of(input int nentries);
    return $clog2(nentries);
  endfunction

  localparam int IW_DEF = iw_of(NENTRIES_DEF);
  localparam int TW_DEF = AW_DEF - IW_DEF - 2;

  typedef struct packed {
    logic              valid;
    logic [TW_DEF-1:0] tag;
    logic [AW_DEF-1:0] target;
    logic              pred;
  } bp_entry_t;

endpackage

// File: rtl/prediction_table_if.sv
// IF-stage lookup and ID-stage update bundle for the branch target buffer.
interface prediction_table_if import bp_pkg::*; #(
  parameter int AW = AW_DEF
);
  logic [AW-1:0] pc4;
  logic [AW-1:0] baddr_s2;
  logic [AW-1:0] pc4_s2;
  logic          WRt;
  logic          WRp;
  logic          C;
  logic          H;
  logic          P;
  logic [AW-1:0] Target;

  modport master (
    output pc4, baddr_s2, pc4_s2, WRt, WRp, C,
    input  H, P, Target
  );

  modport slave (
    input  pc4, baddr_s2, pc4_s2, WRt, WRp, C,
    output H, P, Target
  );
endinterface

// File: rtl/prediction_table_entry.sv
// One BTB slot: valid/tag/target/pred flops with the allocate and
// prediction-update rules applied when the slot is selected.
module prediction_table_entry #(
  parameter int AW = 32,
  parameter int TW = 26
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          sel,
  input  logic          wrt,
  input  logic          wrp,
  input  logic          c,
  input  logic [TW-1:0] wtag,
  input  logic [AW-1:0] wdata,
  output logic          valid,
  output logic [TW-1:0] tag,
  output logic [AW-1:0] target,
  output logic          pred
);

  // A prediction-only update must not touch a slot owned by another branch.
  logic pred_we;
  assign pred_we = sel && wrp && (wrt || (valid && tag == wtag));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid  <= 1'b0;
      tag    <= '0;
      target <= '0;
    end else if (sel && wrt) begin
      valid  <= 1'b1;
      tag    <= wtag;
      target <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       pred <= 1'b0;
    else if (pred_we) pred <= c;
  end

endmodule

// File: rtl/prediction_table.sv
// Direct-mapped BTB with 1-bit predictor: combinational lookup on IF PC+4,
// single-edge allocate/correct from ID.
module prediction_table import bp_pkg::*; #(
  parameter int NENTRIES = NENTRIES_DEF,
  parameter int AW       = AW_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  prediction_table_if.slave bus
);

  localparam int IW = iw_of(NENTRIES);
  localparam int TW = AW - IW - 2;

  typedef struct packed {
    logic          valid;
    logic [TW-1:0] tag;
    logic [AW-1:0] target;
    logic          pred;
  } entry_t;

  entry_t [NENTRIES-1:0] ent;

  logic [IW-1:0] ridx, widx;
  logic [TW-1:0] rtag, wtag;

  assign ridx = bus.pc4[IW+1:2];
  assign rtag = bus.pc4[AW-1:IW+2];
  assign widx = bus.pc4_s2[IW+1:2];
  assign wtag = bus.pc4_s2[AW-1:IW+2];

  // Word-aligned keys: byte-offset bits carry no information.
  logic unused_lo;
  assign unused_lo = ^{bus.pc4[1:0], bus.pc4_s2[1:0]};

  for (genvar i = 0; i < NENTRIES; i++) begin : g_ent
    prediction_table_entry #(.AW(AW), .TW(TW)) u_ent (
      .clk    (clk),
      .rst_n  (rst_n),
      .sel    (widx == IW'(i)),
      .wrt    (bus.WRt),
      .wrp    (bus.WRp),
      .c      (bus.C),
      .wtag   (wtag),
      .wdata  (bus.baddr_s2),
      .valid  (ent[i].valid),
      .tag    (ent[i].tag),
      .target (ent[i].target),
      .pred   (ent[i].pred)
    );
  end

  // Read straight from the flops: a same-cycle write is not forwarded.
  entry_t re;
  logic   hit;
  assign re  = ent[ridx];
  assign hit = re.valid && (re.tag == rtag);

  assign bus.H      = hit;
  assign bus.P      = hit && re.pred;
  assign bus.Target = hit ? re.target : '0;

endmodule

// File: tb/tb_prediction_table.sv
// Self-checking bench for prediction_table: directed vector table, reset and
// same-cycle corner sequences, then random traffic against an array model.
module tb_prediction_table;
  localparam int N  = 16;
  localparam int AW = 32;
  localparam int IW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  prediction_table_if #(.AW(AW)) bus();
  prediction_table #(.NENTRIES(N), .AW(AW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int tests = 0;
  int fails = 0;

  // Reference model: one record per slot, indexed by plain arithmetic.
  bit            mv [N];
  logic [AW-1:0] mt [N];
  logic [AW-1:0] mtg[N];
  bit            mp [N];

  function automatic int idx_of(input logic [AW-1:0] k);
    return int'((k / 4) % N);
  endfunction

  function automatic logic [AW-1:0] tag_of(input logic [AW-1:0] k);
    return k / (4 * N);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      mv[i] = 0; mt[i] = '0; mtg[i] = '0; mp[i] = 0;
    end
  endtask

  task automatic model_write(input logic [AW-1:0] k, input logic [AW-1:0] d,
                             input bit wrt, input bit wrp, input bit c);
    int  j;
    bit  owned;
    j = idx_of(k);
    owned = mv[j] && (mt[j] == tag_of(k));
    if (wrp && (wrt || owned)) mp[j] = c;
    if (wrt) begin
      mv[j] = 1; mt[j] = tag_of(k); mtg[j] = d;
    end
  endtask

  task automatic check(input string nm, input logic eh, input logic ep,
                       input logic [AW-1:0] et);
    tests++;
    if ({bus.H, bus.P, bus.Target} !== {eh, ep, et}) begin
      fails++;
      $display("FAIL %s: pc4=%h got H=%b P=%b Target=%h, want H=%b P=%b Target=%h",
               nm, bus.pc4, bus.H, bus.P, bus.Target, eh, ep, et);
    end
  endtask

  task automatic check_model(input string nm);
    int j;
    bit h;
    j = idx_of(bus.pc4);
    h = mv[j] && (mt[j] == tag_of(bus.pc4));
    check(nm, h, h && mp[j], h ? mtg[j] : '0);
  endtask

  task automatic idle();
    bus.WRt = 0; bus.WRp = 0; bus.C = 0;
  endtask

  task automatic do_write(input logic [AW-1:0] k, input logic [AW-1:0] d,
                          input bit wrt, input bit wrp, input bit c);
    @(negedge clk);
    bus.pc4_s2 = k; bus.baddr_s2 = d; bus.WRt = wrt; bus.WRp = wrp; bus.C = c;
    @(posedge clk);
    model_write(k, d, wrt, wrp, c);
    #1 idle();
  endtask

  typedef struct {
    string         nm;
    logic [AW-1:0] wkey;
    logic [AW-1:0] wdata;
    bit            wrt;
    bit            wrp;
    bit            c;
    logic [AW-1:0] key;
    logic          eh;
    logic          ep;
    logic [AW-1:0] et;
  } vec_t;

  vec_t vecs[11];

  initial begin
    vecs[0]  = '{"wrp_to_empty_miss", 32'h94, 32'h0,   0, 1, 1, 32'h94, 0, 0, 32'h0};
    vecs[1]  = '{"alloc_taken",       32'h14, 32'h40,  1, 1, 1, 32'h14, 1, 1, 32'h40};
    vecs[2]  = '{"alloc_not_taken",   32'h24, 32'h80,  1, 1, 0, 32'h24, 1, 0, 32'h80};
    vecs[3]  = '{"correct_pred",      32'h24, 32'h999, 0, 1, 1, 32'h24, 1, 1, 32'h80};
    vecs[4]  = '{"tag_mismatch_prot", 32'h54, 32'h0,   0, 1, 0, 32'h14, 1, 1, 32'h40};
    vecs[5]  = '{"evict_old",         32'h54, 32'h100, 1, 1, 0, 32'h14, 0, 0, 32'h0};
    vecs[6]  = '{"evict_new",         32'h0,  32'h0,   0, 0, 0, 32'h54, 1, 0, 32'h100};
    vecs[7]  = '{"pred_set_alias",    32'h54, 32'h0,   0, 1, 1, 32'h54, 1, 1, 32'h100};
    vecs[8]  = '{"wrt_only_keeps_p",  32'h54, 32'h104, 1, 0, 0, 32'h54, 1, 1, 32'h104};
    vecs[9]  = '{"wrt_only_empty",    32'h98, 32'h200, 1, 0, 1, 32'h98, 1, 0, 32'h200};
    vecs[10] = '{"low_bits_ignored",  32'h0,  32'h0,   0, 0, 0, 32'h57, 1, 1, 32'h104};

    idle();
    bus.pc4 = 32'h14; bus.pc4_s2 = '0; bus.baddr_s2 = '0;
    model_reset();

    // Power-on reset, released away from the rising edge.
    repeat (2) @(posedge clk);
    #1 check("reset_in", 0, 0, '0);
    @(negedge clk) rst_n = 1;
    #1 check("reset_out", 0, 0, '0);

    for (int i = 0; i < 11; i++) begin
      do_write(vecs[i].wkey, vecs[i].wdata, vecs[i].wrt, vecs[i].wrp, vecs[i].c);
      bus.pc4 = vecs[i].key;
      #1 check(vecs[i].nm, vecs[i].eh, vecs[i].ep, vecs[i].et);
      check_model({vecs[i].nm, "_model"});
    end

    // Asynchronous reset mid-run, held across an edge with a write pending.
    @(posedge clk); #2;
    bus.pc4 = 32'h54;
    bus.pc4_s2 = 32'h28; bus.baddr_s2 = 32'h300; bus.WRt = 1; bus.WRp = 1; bus.C = 1;
    rst_n = 0;
    #1 check("async_reset_clears", 0, 0, '0);
    @(posedge clk);
    @(negedge clk) rst_n = 1;
    idle();
    model_reset();
    bus.pc4 = 32'h28;
    #1 check("reset_wins_write", 0, 0, '0);
    bus.pc4 = 32'h14;
    #1 check("reset_plan_lookup", 0, 0, '0);

    // Same-cycle lookup of the index being written sees pre-edge contents.
    @(negedge clk);
    bus.pc4 = 32'h14;
    bus.pc4_s2 = 32'h14; bus.baddr_s2 = 32'h40; bus.WRt = 1; bus.WRp = 1; bus.C = 1;
    #1 check("no_bypass_same_cycle", 0, 0, '0);
    @(posedge clk);
    model_write(32'h14, 32'h40, 1, 1, 1);
    #1 idle();
    check("visible_next_cycle", 1, 1, 32'h40);

    // Random traffic: small tag space forces aliasing and evictions.
    for (int n = 0; n < 400; n++) begin
      logic [AW-1:0] wk, rk;
      wk = (AW'($urandom_range(0, 3)) << (IW + 2)) | (AW'($urandom_range(0, N - 1)) << 2)
         | AW'($urandom_range(0, 3));
      rk = ($urandom_range(0, 3) == 0) ? wk
         : (AW'($urandom_range(0, 3)) << (IW + 2)) | (AW'($urandom_range(0, N - 1)) << 2);
      @(negedge clk);
      bus.pc4 = rk;
      bus.pc4_s2 = wk; bus.baddr_s2 = $urandom;
      bus.WRt = 1'($urandom); bus.WRp = 1'($urandom); bus.C = 1'($urandom);
      #1 check_model("rand_pre_edge");
      @(posedge clk);
      model_write(wk, bus.baddr_s2, bus.WRt, bus.WRp, bus.C);
      #1 idle();
      check_model("rand_post_edge");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/prediction_table.md
# prediction_table

Direct-mapped branch target buffer with a 1-bit taken/not-taken predictor, used by the five-stage MIPS pipeline. Fetch (IF) looks it up combinationally with PC+4 to decide whether the next PC is the predicted branch target. Decode (ID) allocates or corrects entries once the branch outcome is resolved.

## Interface
- `NENTRIES`, default 16: number of entries; must be a power of two, at least 2.
- `AW`, default 32: address width.
- `clk`  in  1: clock; all writes occur on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `pc4`  in  AW: lookup key, the PC+4 of the instruction being fetched (IF).
- `baddr_s2`  in  AW: branch target computed in ID; the target data to store.
- `pc4_s2`  in  AW: write key, the PC+4 of the branch in ID.
- `WRt`  in  1: allocate. Writes valid, tag and target at `pc4_s2`.
- `WRp`  in  1: writes the prediction bit at `pc4_s2`.
- `C`  in  1: resolved branch outcome (1 = taken, i.e. rs == rt); the value written to the prediction bit.
- `H`  out  1: lookup hit.
- `P`  out  1: predicted taken.
- `Target`  out  AW: predicted target address.

## Operation
- **Index and tag.** For any key k:
  - IW = log2(NENTRIES).
  - index = k[IW+1:2].
  - tag = k[AW-1:IW+2].
  - k[1:0] is ignored.
- **Entry contents.** Each entry holds: valid, tag, target (AW bits), pred (1 bit).
- **Lookup (combinational from `pc4`).**
  - H = valid[idx] && tag[idx] == tag(pc4).
  - When H=1: P = pred[idx] and Target = target[idx].
  - When H=0: P=0 and Target=0.
- **Write on posedge.** Let j = index(pc4_s2).
  - `WRt`=1: valid[j]=1, tag[j]=tag(pc4_s2), target[j]=baddr_s2. Any previous occupant of the index is overwritten.
  - `WRp`=1 with `WRt`=1: pred[j]=C.
  - `WRp`=1 with `WRt`=0: pred[j]=C only if valid[j] and the tag matches pc4_s2; otherwise no change.
  - `WRt`=1 with `WRp`=0: pred[j] keeps its old value. If the entry was previously invalid, pred[j] is 0.
  - Both low: no state change.
- **Reset.** All valid bits, pred bits and targets are cleared. Outputs are therefore H=0, P=0, Target=0.
- **Simultaneous events.**
  - A lookup and a write to the same index in the same cycle return the pre-edge contents; there is no write-to-read bypass.
  - Reset asserted mid-write wins; the write is discarded.
- **Caller conventions (pipeline).**
  - Miss and not-taken branch: WRt=WRp=1 with C=0 (allocate, predict not-taken).
  - Miss and taken branch: WRt=WRp=1 with C=1.
  - Mispredicted hit: WRp=1, WRt=0.

## Timing
- Lookup: zero latency; H/P/Target are a pure function of `pc4` and the current state.
- Write: one cycle. Visible to lookups in the cycle after the rising edge.
- No handshakes; inputs are sampled every edge.
- `rst_n` asserts asynchronously and is released synchronously by the parent's reset synchronizer.

## Structure
- Shared package `bp_pkg`: `AW` default, `NENTRIES` default, IW derivation function, and an entry typedef {valid, tag, target, pred}.
- Single module. Storage is a flop array (no SRAM macro) so that reset clears it and the lookup read is asynchronous.
- `alu` and `alu_control` are separate EX-stage blocks specified elsewhere; they are not part of this module.

## Test plan
- **Reset.** Assert rst_n=0 mid-run, then release; look up pc4=0x14 → H=0, P=0, Target=0.
- **Allocate taken.**
  - Stimulus: pc4_s2=0x14, baddr_s2=0x40, C=1, WRt=WRp=1, one edge; then pc4=0x14.
  - Required: H=1, P=1, Target=0x40.
  - Same cycle as the write: H=0.
- **Allocate not-taken, then correct.**
  - Allocate 0x24 → 0x80 with C=0: expect H=1, P=0, Target=0x80.
  - Then WRp=1, WRt=0, C=1: expect P=1, Target still 0x80.
- **Alias and eviction.**
  - After 0x14 is allocated, allocate 0x54 (same index 5, different tag) → 0x100.
  - Required: lookup 0x14 gives H=0; lookup 0x54 gives H=1, Target=0x100.
- **Prediction-only write to a miss.** WRp=1, WRt=0 at pc4_s2=0x94 with an empty index → no state change; lookup 0x94 gives H=0.
- **Tag mismatch protection.** With 0x14 valid, WRp=1, C=0 at pc4_s2=0x54 → pred of 0x14 unchanged.
